// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between the instruction cache and the data cache.
//
// The dcache gets priority and keeps the grant for a whole burst of BURST_LEN word completions.
// That way the beats of one block are never interleaved with icache fetches. A starve counter
// counts consecutive dcache grants taken while the icache was waiting. Once it reaches
// STARVE_MAX, the icache wins the next arbitration.
//
// Ports
//   CLK, RST              clock (rising edge) and asynchronous active-high reset
//   iREN, iaddr           icache read request and word address
//   iwait, iload          icache wait (0 = word complete) and read data
//   dREN, dWEN            dcache read / write request (write wins when both are set)
//   daddr, dstore         dcache word address and write data
//   dwait, dload          dcache wait (0 = word complete) and read data
//   ramREN, ramWEN        RAM read / write enables
//   ramaddr, ramstore     RAM address and write data
//   ramload, ramstate     RAM read data and status (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR)
module mem_arbiter #(
  parameter int unsigned BURST_LEN  = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam logic [1:0] RamAccess  = 2'd2;
  localparam logic [1:0] LastBeat   = 2'(BURST_LEN - 1);
  localparam logic [2:0] StarveFull = 3'(STARVE_MAX);

  typedef enum logic [1:0] {
    GntNone,
    GntI,
    GntD
  } gnt_t;

  gnt_t       gnt;
  logic [1:0] beat;
  logic [2:0] starve;

  logic access;
  logic done;
  logic d_req;
  logic starved;

  assign access  = (ramstate == RamAccess);
  // BUSY, FREE and ERROR never complete a word; the request stays on the port until ACCESS.
  assign done    = (gnt != GntNone) && access;
  assign d_req   = dREN | dWEN;
  assign starved = iREN && (starve == StarveFull);

  // Grant state, burst beat counter and icache starvation counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt    <= GntNone;
      beat   <= '0;
      starve <= '0;
    end else begin
      unique case (gnt)
        GntNone: begin
          if (d_req && !starved) begin
            gnt  <= GntD;
            beat <= '0;
            if (!iREN) begin
              starve <= '0;
            end else if (starve != StarveFull) begin
              starve <= starve + 3'd1;
            end
          end else if (iREN) begin
            gnt <= GntI;
          end
        end
        GntD: begin
          if (done) begin
            if (beat == LastBeat) begin
              gnt  <= GntNone;
              beat <= '0;
            end else begin
              beat <= beat + 2'd1;
            end
          end else if (!d_req) begin
            // Dcache dropped its request mid-burst: release without finishing the block.
            gnt  <= GntNone;
            beat <= '0;
          end
        end
        GntI: begin
          if (done || !iREN) begin
            gnt    <= GntNone;
            starve <= '0;
          end
        end
        default: begin
          gnt    <= GntNone;
          beat   <= '0;
          starve <= '0;
        end
      endcase
    end
  end

  // Port steering depends only on the registered grant, so reset idles the RAM port at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
    unique case (gnt)
      GntI: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = ~access;
      end
      GntD: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dwait    = ~access;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs are driven on the falling edge, and outputs are
// sampled 1 time unit later, so each "cycle" below is the clock period that follows a rising edge.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  localparam logic [1:0] Free   = 2'd0;
  localparam logic [1:0] Busy   = 2'd1;
  localparam logic [1:0] Access = 2'd2;
  localparam logic [1:0] Error  = 2'd3;

  mem_arbiter #(
    .BURST_LEN (2),
    .STARVE_MAX(4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    iREN     = 1'b0;
    iaddr    = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ramstate = Free;
  endtask

  // Hold reset across two rising edges; release on a falling edge, leaving the DUT in cycle 1.
  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Owner of the RAM port as seen on its pins: 0 none, 1 icache, 2 dcache.
  function automatic logic [31:0] owner();
    if (ramaddr == 32'h80) return 32'd1;
    if (ramaddr == 32'h200) return 32'd2;
    return 32'd0;
  endfunction

  // Expected port owner per cycle with iREN held and dcache bursts back to back.
  logic [31:0] starve_exp [16] = '{0, 2, 2, 0, 2, 2, 0, 2, 2, 0, 2, 2, 0, 1, 0, 2};

  initial begin
    // Reset state
    idle_inputs();
    RST = 1'b1;
    #1;
    check_eq("rst_iwait", 32'(iwait), 32'd1);
    check_eq("rst_dwait", 32'(dwait), 32'd1);
    check_eq("rst_ramREN", 32'(ramREN), 32'd0);
    check_eq("rst_ramWEN", 32'(ramWEN), 32'd0);
    check_eq("rst_iload", iload, 32'd0);
    check_eq("rst_dload", dload, 32'd0);

    // Single icache read
    do_reset();
    iREN = 1'b1; iaddr = 32'h40; ramload = 32'hDEADBEEF;
    #1;
    check_eq("i1_c1_ramREN", 32'(ramREN), 32'd0);
    check_eq("i1_c1_iwait", 32'(iwait), 32'd1);
    @(negedge CLK);
    ramstate = Access;
    #1;
    check_eq("i1_c2_ramREN", 32'(ramREN), 32'd1);
    check_eq("i1_c2_ramaddr", ramaddr, 32'h40);
    check_eq("i1_c2_iwait", 32'(iwait), 32'd0);
    check_eq("i1_c2_iload", iload, 32'hDEADBEEF);
    @(negedge CLK);
    #1;
    check_eq("i1_c3_ramREN", 32'(ramREN), 32'd0);
    check_eq("i1_c3_iwait", 32'(iwait), 32'd1);
    check_eq("i1_c3_ramaddr", ramaddr, 32'd0);

    // Simultaneous requests: dcache burst first, icache after one idle cycle
    do_reset();
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
    ramstate = Access; ramload = 32'hCAFE0001;
    #1;
    check_eq("pr_c1_ramREN", 32'(ramREN), 32'd0);
    @(negedge CLK);
    #1;
    check_eq("pr_b0_ramaddr", ramaddr, 32'h100);
    check_eq("pr_b0_ramREN", 32'(ramREN), 32'd1);
    check_eq("pr_b0_dwait", 32'(dwait), 32'd0);
    check_eq("pr_b0_dload", dload, 32'hCAFE0001);
    check_eq("pr_b0_iwait", 32'(iwait), 32'd1);
    check_eq("pr_b0_iload", iload, 32'd0);
    @(negedge CLK);
    daddr = 32'h104;
    #1;
    check_eq("pr_b1_ramaddr", ramaddr, 32'h104);
    check_eq("pr_b1_iwait", 32'(iwait), 32'd1);
    @(negedge CLK);
    dREN = 1'b0;
    #1;
    check_eq("pr_gap_ramREN", 32'(ramREN), 32'd0);
    check_eq("pr_gap_iwait", 32'(iwait), 32'd1);
    check_eq("pr_gap_dwait", 32'(dwait), 32'd1);
    @(negedge CLK);
    #1;
    check_eq("pr_i_ramaddr", ramaddr, 32'h44);
    check_eq("pr_i_iwait", 32'(iwait), 32'd0);
    check_eq("pr_i_dwait", 32'(dwait), 32'd1);

    // Write burst stalled by BUSY; beats advance only on ACCESS
    do_reset();
    dWEN = 1'b1; daddr = 32'h300; dstore = 32'h12345678; ramstate = Busy;
    for (int c = 2; c <= 4; c++) begin
      @(negedge CLK);
      #1;
      check_eq($sformatf("wb_busy%0d_ramWEN", c), 32'(ramWEN), 32'd1);
      check_eq($sformatf("wb_busy%0d_dwait", c), 32'(dwait), 32'd1);
    end
    check_eq("wb_ramstore", ramstore, 32'h12345678);
    check_eq("wb_ramREN", 32'(ramREN), 32'd0);
    @(negedge CLK);
    ramstate = Access;
    #1;
    check_eq("wb_b0_dwait", 32'(dwait), 32'd0);
    @(negedge CLK);
    #1;
    check_eq("wb_b1_ramWEN", 32'(ramWEN), 32'd1);
    check_eq("wb_b1_dwait", 32'(dwait), 32'd0);
    @(negedge CLK);
    #1;
    check_eq("wb_rel_ramWEN", 32'(ramWEN), 32'd0);
    check_eq("wb_rel_dwait", 32'(dwait), 32'd1);

    // Starvation bound: icache forced in after four dcache grants
    do_reset();
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200; ramstate = Access;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge CLK);
      #1;
      check_eq($sformatf("sv_c%0d_owner", c + 1), owner(), starve_exp[c]);
    end

    // Read and write together: write wins; then an aborted burst releases the port
    do_reset();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h500; ramstate = Free;
    @(negedge CLK);
    #1;
    check_eq("rw_ramWEN", 32'(ramWEN), 32'd1);
    check_eq("rw_ramREN", 32'(ramREN), 32'd0);
    @(negedge CLK);
    dREN = 1'b0; dWEN = 1'b0;
    #1;
    check_eq("ab_ramWEN", 32'(ramWEN), 32'd0);
    check_eq("ab_ramaddr_held", ramaddr, 32'h500);
    @(negedge CLK);
    #1;
    check_eq("ab_rel_ramaddr", ramaddr, 32'd0);

    // Asynchronous reset during beat 1 of a writeback
    do_reset();
    dWEN = 1'b1; daddr = 32'h600; dstore = 32'hA5A5A5A5; ramstate = Access;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check_eq("ar_b1_ramWEN", 32'(ramWEN), 32'd1);
    RST = 1'b1;
    #1;
    check_eq("ar_async_ramWEN", 32'(ramWEN), 32'd0);
    check_eq("ar_async_dwait", 32'(dwait), 32'd1);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_eq("ar_c1_ramWEN", 32'(ramWEN), 32'd0);
    @(negedge CLK);
    #1;
    check_eq("ar_b0_ramWEN", 32'(ramWEN), 32'd1);
    @(negedge CLK);
    #1;
    check_eq("ar_b1_again_ramWEN", 32'(ramWEN), 32'd1);
    @(negedge CLK);
    dWEN = 1'b0;
    #1;
    check_eq("ar_rel_ramWEN", 32'(ramWEN), 32'd0);

    // ERROR during an icache grant is not a completion
    do_reset();
    iREN = 1'b1; iaddr = 32'h700; ramload = 32'h0BADF00D; ramstate = Error;
    for (int c = 2; c <= 3; c++) begin
      @(negedge CLK);
      #1;
      check_eq($sformatf("er_c%0d_iwait", c), 32'(iwait), 32'd1);
      check_eq($sformatf("er_c%0d_ramREN", c), 32'(ramREN), 32'd1);
    end
    @(negedge CLK);
    ramstate = Access;
    #1;
    check_eq("er_acc_iwait", 32'(iwait), 32'd0);
    check_eq("er_acc_iload", iload, 32'h0BADF00D);
    @(negedge CLK);
    iREN = 1'b0;
    #1;
    check_eq("er_rel_ramREN", 32'(ramREN), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
